// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
//   Shared constants for the MEM/WB writeback stage of the 5-stage MIPS
//   pipeline: writeback source selects, load format codes and the link
//   offset used for jump-and-link writeback.
//
//   Contents:
//     wb_sel_e    - writeback source select (2 bits, code 3 reserved)
//     ld_type_e   - load format (3 bits, codes 5..7 reserved)
//     LINK_OFFSET - return address offset past the branch delay slot
//     sext8/sext16/zext8/zext16 - lane extension helpers
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'd0,
      WB_SEL_MEM  = 2'd1,
      WB_SEL_LINK = 2'd2,
      WB_SEL_RSVD = 2'd3
   } wb_sel_e;

   typedef enum logic [2:0] {
      LD_W     = 3'd0,
      LD_H     = 3'd1,
      LD_HU    = 3'd2,
      LD_B     = 3'd3,
      LD_BU    = 3'd4,
      LD_RSVD5 = 3'd5,
      LD_RSVD6 = 3'd6,
      LD_RSVD7 = 3'd7
   } ld_type_e;

   // Link register receives PC+8: the instruction after the delay slot.
   localparam logic [31:0] LINK_OFFSET = 32'd8;

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] zext8(input logic [7:0] b);
      return {24'd0, b};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

   function automatic logic [31:0] zext16(input logic [15:0] h);
      return {16'd0, h};
   endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//   Combinational load formatter. Picks the byte or halfword lane out of the
//   raw aligned memory word (little-endian lanes) and sign/zero-extends it.
//   Flags alignment violations and reserved load codes as misaligned.
//
//   Ports:
//     ld_type  in  3   load format (ld_type_e)
//     addr_lo  in  2   data address bits [1:0]
//     raw      in  32  raw aligned word from data memory
//     data     out 32  formatted load value
//     misalign out 1   access not legal for this load format
// ---------------------------------------------------------------------------
module load_extend
   import mem_wb_stage_pkg::*;
(
   input  logic [2:0]  ld_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] raw,
   output logic [31:0] data,
   output logic        misalign
);

   logic [7:0]  byte_lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Split the word into its four byte lanes; lane gi holds address offset gi.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = raw[8*gi +: 8];
   end

   assign byte_sel = byte_lane[addr_lo];
   assign half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

   always_comb begin
      data     = 32'd0;
      misalign = 1'b0;
      case (ld_type_e'(ld_type))
         LD_W: begin
            data     = raw;
            misalign = (addr_lo != 2'd0);
         end
         LD_H: begin
            data     = sext16(half_sel);
            misalign = addr_lo[0];
         end
         LD_HU: begin
            data     = zext16(half_sel);
            misalign = addr_lo[0];
         end
         LD_B:  data = sext8(byte_sel);
         LD_BU: data = zext8(byte_sel);
         default: begin
            // Reserved formats are rejected the same way as bad alignment.
            data     = raw;
            misalign = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline latch and writeback formatter. Captures the memory-stage
//   result on the rising edge, selects the writeback source, formats
//   sub-word loads and drives the register-file write port. The register
//   file writes on the falling edge, so these flop outputs are stable for
//   half a cycle before the write and for the whole cycle as the EX
//   forwarding source.
//
//   Ports:
//     CLK          in  1   pipeline clock (posedge)
//     RST          in  1   synchronous active-high reset
//     stall        in  1   hold all WB state
//     flush        in  1   insert bubble (overrides stall)
//     mem_valid    in  1   MEM holds a real instruction
//     mem_rwd      in  5   destination register (0 = no write)
//     mem_wb_sel   in  2   writeback source (wb_sel_e)
//     mem_ld_type  in  3   load format (ld_type_e)
//     mem_addr_lo  in  2   data address bits [1:0]
//     mem_alu_res  in  32  ALU result
//     mem_ld_data  in  32  raw aligned data memory word
//     mem_pc       in  32  PC of the MEM instruction
//     rwd          out 5   register-file write index
//     wb_data      out 32  register-file write data
//     wb_valid     out 1   WB holds a real instruction
//     wb_misalign  out 1   captured load was misaligned, write suppressed
//     retired_cnt  out 32  count of valid instructions captured (wraps)
// ---------------------------------------------------------------------------
module mem_wb_stage
   import mem_wb_stage_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        stall,
   input  logic        flush,
   input  logic        mem_valid,
   input  logic [4:0]  mem_rwd,
   input  logic [1:0]  mem_wb_sel,
   input  logic [2:0]  mem_ld_type,
   input  logic [1:0]  mem_addr_lo,
   input  logic [31:0] mem_alu_res,
   input  logic [31:0] mem_ld_data,
   input  logic [31:0] mem_pc,
   output logic [4:0]  rwd,
   output logic [31:0] wb_data,
   output logic        wb_valid,
   output logic        wb_misalign,
   output logic [31:0] retired_cnt
);

   logic [31:0] ld_fmt;
   logic        ld_misalign;

   logic [4:0]  cap_rwd;
   logic [31:0] cap_data;
   logic        cap_misalign;

   logic [4:0]  rwd_reg,         rwd_next;
   logic [31:0] wb_data_reg,     wb_data_next;
   logic        wb_valid_reg,    wb_valid_next;
   logic        wb_misalign_reg, wb_misalign_next;
   logic [31:0] retired_cnt_reg, retired_cnt_next;

   load_extend u_load_extend (
      .ld_type  (mem_ld_type),
      .addr_lo  (mem_addr_lo),
      .raw      (mem_ld_data),
      .data     (ld_fmt),
      .misalign (ld_misalign)
   );

   // Writeback value for a valid instruction. Load format and alignment only
   // matter when the source is memory.
   always_comb begin
      cap_rwd      = mem_rwd;
      cap_data     = 32'd0;
      cap_misalign = 1'b0;
      case (wb_sel_e'(mem_wb_sel))
         WB_SEL_ALU: cap_data = mem_alu_res;
         WB_SEL_MEM: begin
            if (ld_misalign) begin
               // Suppress the write but keep the raw word visible for debug.
               cap_rwd      = 5'd0;
               cap_misalign = 1'b1;
               cap_data     = mem_ld_data;
            end else begin
               cap_data = ld_fmt;
            end
         end
         WB_SEL_LINK: cap_data = mem_pc + LINK_OFFSET;
         default: begin
            cap_rwd  = 5'd0;
            cap_data = 32'd0;
         end
      endcase
   end

   // Flush (or an empty MEM slot when not stalled) makes a bubble: write
   // index and flags clear, wb_data and the counter keep their values.
   always_comb begin
      rwd_next         = rwd_reg;
      wb_data_next     = wb_data_reg;
      wb_valid_next    = wb_valid_reg;
      wb_misalign_next = wb_misalign_reg;
      retired_cnt_next = retired_cnt_reg;
      if (flush || (!stall && !mem_valid)) begin
         rwd_next         = 5'd0;
         wb_valid_next    = 1'b0;
         wb_misalign_next = 1'b0;
      end else if (!stall) begin
         rwd_next         = cap_rwd;
         wb_data_next     = cap_data;
         wb_valid_next    = 1'b1;
         wb_misalign_next = cap_misalign;
         retired_cnt_next = retired_cnt_reg + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rwd_reg         <= 5'd0;
         wb_data_reg     <= 32'd0;
         wb_valid_reg    <= 1'b0;
         wb_misalign_reg <= 1'b0;
         retired_cnt_reg <= 32'd0;
      end else begin
         rwd_reg         <= rwd_next;
         wb_data_reg     <= wb_data_next;
         wb_valid_reg    <= wb_valid_next;
         wb_misalign_reg <= wb_misalign_next;
         retired_cnt_reg <= retired_cnt_next;
      end
   end

   assign rwd         = rwd_reg;
   assign wb_data     = wb_data_reg;
   assign wb_valid    = wb_valid_reg;
   assign wb_misalign = wb_misalign_reg;
   assign retired_cnt = retired_cnt_reg;

endmodule
